// File: rtl/symbol_hist_sort_if.sv
// Bundles the sample stream and the histogram / sorted-result outputs of symbol_hist_sort.
// The slave modport is used by the design and the master modport by its driver.
interface symbol_hist_sort_if;
   logic       gray_valid;
   logic [7:0] gray_data;
   logic       CNT_valid;
   logic [7:0] CNT1, CNT2, CNT3, CNT4, CNT5, CNT6;
   logic       sort_valid;
   logic [7:0] SYM1, SYM2, SYM3, SYM4, SYM5, SYM6;
   logic [7:0] SCNT1, SCNT2, SCNT3, SCNT4, SCNT5, SCNT6;

   modport slave (
      input  gray_valid, gray_data,
      output CNT_valid, CNT1, CNT2, CNT3, CNT4, CNT5, CNT6,
      output sort_valid, SYM1, SYM2, SYM3, SYM4, SYM5, SYM6,
      output SCNT1, SCNT2, SCNT3, SCNT4, SCNT5, SCNT6
   );

   modport master (
      output gray_valid, gray_data,
      input  CNT_valid, CNT1, CNT2, CNT3, CNT4, CNT5, CNT6,
      input  sort_valid, SYM1, SYM2, SYM3, SYM4, SYM5, SYM6,
      input  SCNT1, SCNT2, SCNT3, SCNT4, SCNT5, SCNT6
   );
endinterface

// File: rtl/symbol_hist_sort.sv
// Counts symbols 1..6 over a gray_valid frame, then ranks them by count with a 6-pass
// odd-even transposition sort. Define CNT_SAT_EN to saturate counts at 255 instead of wrapping.
module symbol_hist_sort (
   input  logic               clk,
   input  logic               reset,
   symbol_hist_sort_if.slave  bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      SORT = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [5:0][7:0] cnt_q, cnt_d;
   logic [5:0][7:0] sym_q, sym_d;
   logic [5:0][7:0] scnt_q, scnt_d;
   logic [2:0]      pass_q, pass_d;
   logic            cnt_valid_q, cnt_valid_d;
   logic            sort_valid_q, sort_valid_d;

   function automatic logic [7:0] cnt_inc(input logic [7:0] v);
`ifdef CNT_SAT_EN
      cnt_inc = (v == 8'hFF) ? v : v + 8'd1;
`else
      cnt_inc = v + 8'd1;
`endif
   endfunction

   // Out-of-range symbols match no slot, so they leave the histogram untouched.
   function automatic logic [5:0][7:0] count_sample(input logic [5:0][7:0] c,
                                                    input logic [7:0]      data);
      count_sample = c;
      for (int i = 0; i < 6; i++) begin
         if (data == 8'(i + 1)) begin
            count_sample[i] = cnt_inc(c[i]);
         end else begin
            count_sample[i] = c[i];
         end
      end
   endfunction

   // Next-state, histogram update and one sort pass per SORT cycle.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      sym_d        = sym_q;
      scnt_d       = scnt_q;
      pass_d       = pass_q;
      cnt_valid_d  = 1'b0;
      sort_valid_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.gray_valid) begin
               cnt_d   = count_sample('0, bus.gray_data);
               state_d = READ;
            end else begin
               state_d = IDLE;
            end
         end
         READ: begin
            if (bus.gray_valid) begin
               cnt_d = count_sample(cnt_q, bus.gray_data);
            end else begin
               cnt_valid_d = 1'b1;
               pass_d      = 3'd1;
               state_d     = SORT;
               for (int i = 0; i < 6; i++) begin
                  sym_d[i] = 8'(i + 1);
               end
               scnt_d = cnt_q;
            end
         end
         SORT: begin
            // Odd passes compare slots (1,2)(3,4)(5,6); even passes (2,3)(4,5).
            for (int i = 0; i < 5; i++) begin
               if (((i % 2) != int'(pass_q[0])) && (scnt_q[i] < scnt_q[i + 1])) begin
                  sym_d[i]      = sym_q[i + 1];
                  sym_d[i + 1]  = sym_q[i];
                  scnt_d[i]     = scnt_q[i + 1];
                  scnt_d[i + 1] = scnt_q[i];
               end else begin
                  sym_d[i]  = sym_d[i];
                  scnt_d[i] = scnt_d[i];
               end
            end
            if (pass_q == 3'd6) begin
               sort_valid_d = 1'b1;
               state_d      = DONE;
            end else begin
               pass_d = pass_q + 3'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and result registers; reset leaves the identity ranking with zero counts.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         scnt_q       <= '0;
         pass_q       <= 3'd0;
         cnt_valid_q  <= 1'b0;
         sort_valid_q <= 1'b0;
         for (int i = 0; i < 6; i++) begin
            sym_q[i] <= 8'(i + 1);
         end
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         sym_q        <= sym_d;
         scnt_q       <= scnt_d;
         pass_q       <= pass_d;
         cnt_valid_q  <= cnt_valid_d;
         sort_valid_q <= sort_valid_d;
      end
   end

   assign bus.CNT_valid  = cnt_valid_q;
   assign bus.sort_valid = sort_valid_q;
   assign bus.CNT1  = cnt_q[0];
   assign bus.CNT2  = cnt_q[1];
   assign bus.CNT3  = cnt_q[2];
   assign bus.CNT4  = cnt_q[3];
   assign bus.CNT5  = cnt_q[4];
   assign bus.CNT6  = cnt_q[5];
   assign bus.SYM1  = sym_q[0];
   assign bus.SYM2  = sym_q[1];
   assign bus.SYM3  = sym_q[2];
   assign bus.SYM4  = sym_q[3];
   assign bus.SYM5  = sym_q[4];
   assign bus.SYM6  = sym_q[5];
   assign bus.SCNT1 = scnt_q[0];
   assign bus.SCNT2 = scnt_q[1];
   assign bus.SCNT3 = scnt_q[2];
   assign bus.SCNT4 = scnt_q[3];
   assign bus.SCNT5 = scnt_q[4];
   assign bus.SCNT6 = scnt_q[5];
endmodule

// File: tb/tb_symbol_hist_sort.sv
// Directed self-checking bench for symbol_hist_sort: histogram, sort order, illegal symbols,
// wrap/saturation, reset abort, busy-sample dropping and single-sample frames.
module tb_symbol_hist_sort;
   logic clk;
   logic reset;
   int   n_cmp;
   int   n_bad;

   symbol_hist_sort_if bus ();

   symbol_hist_sort dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [7:0] cnt_o  [6];
   logic [7:0] sym_o  [6];
   logic [7:0] scnt_o [6];
   assign cnt_o  = '{bus.CNT1, bus.CNT2, bus.CNT3, bus.CNT4, bus.CNT5, bus.CNT6};
   assign sym_o  = '{bus.SYM1, bus.SYM2, bus.SYM3, bus.SYM4, bus.SYM5, bus.SYM6};
   assign scnt_o = '{bus.SCNT1, bus.SCNT2, bus.SCNT3, bus.SCNT4, bus.SCNT5, bus.SCNT6};

   // Inputs change at the falling edge; the task returns at the next falling edge.
   task automatic cyc(input logic v, input logic [7:0] d);
      bus.gray_valid = v;
      bus.gray_data  = d;
      @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] s[$]);
      cyc(1'b0, 8'd0);
      foreach (s[i]) cyc(1'b1, s[i]);
      cyc(1'b0, 8'd0);
   endtask

   // Returns the cycle on which sort_valid rose (0 on timeout) and whether CNT_valid was seen.
   task automatic wait_sort(output int n, output logic cnt_seen);
      n = 0;
      cnt_seen = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         cyc(1'b0, 8'd0);
         if (bus.CNT_valid) cnt_seen = 1'b1;
         if (bus.sort_valid) begin
            n = c;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      bus.gray_valid = 1'b0;
      bus.gray_data  = 8'd0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (bus.CNT_valid !== 1'b0 || bus.sort_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_valid: got %b/%b want 0/0", bus.CNT_valid, bus.sort_valid);
      end
      for (int i = 0; i < 6; i++) begin
         n_cmp++;
         if (cnt_o[i] !== 8'd0 || scnt_o[i] !== 8'd0 || sym_o[i] !== 8'(i + 1)) begin
            n_bad++;
            $display("FAIL reset_slot%0d: got cnt=%0d sym=%0d scnt=%0d want 0/%0d/0",
                     i + 1, cnt_o[i], sym_o[i], scnt_o[i], i + 1);
         end
      end
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_histogram();
      logic [7:0] q[$];
      logic [7:0] exp_cnt [6];
      logic [7:0] exp_sym [6];
      logic [7:0] exp_scnt[6];
      int   n;
      logic seen;
      q = '{8'd1, 8'd1, 8'd1, 8'd2, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd6};
      exp_cnt  = '{8'd3, 8'd2, 8'd1, 8'd1, 8'd1, 8'd2};
      exp_sym  = '{8'd1, 8'd2, 8'd6, 8'd3, 8'd4, 8'd5};
      exp_scnt = '{8'd3, 8'd2, 8'd2, 8'd1, 8'd1, 8'd1};
      send_frame(q);
      n_cmp++;
      if (bus.CNT_valid !== 1'b1 || bus.sort_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL hist_cnt_valid: got %b/%b want 1/0", bus.CNT_valid, bus.sort_valid);
      end
      for (int i = 0; i < 6; i++) begin
         n_cmp++;
         if (cnt_o[i] !== exp_cnt[i]) begin
            n_bad++;
            $display("FAIL hist_cnt%0d: got %0d want %0d", i + 1, cnt_o[i], exp_cnt[i]);
         end
      end
      wait_sort(n, seen);
      n_cmp++;
      if (n !== 6 || seen !== 1'b0) begin
         n_bad++;
         $display("FAIL hist_sort_latency: got %0d cycles (cnt_valid_again=%b) want 6/0", n, seen);
      end
      for (int i = 0; i < 6; i++) begin
         n_cmp++;
         if (sym_o[i] !== exp_sym[i] || scnt_o[i] !== exp_scnt[i]) begin
            n_bad++;
            $display("FAIL hist_rank%0d: got sym=%0d scnt=%0d want %0d/%0d",
                     i + 1, sym_o[i], scnt_o[i], exp_sym[i], exp_scnt[i]);
         end
      end
      repeat (2) cyc(1'b0, 8'd0);
      n_cmp++;
      if (bus.sort_valid !== 1'b0 || sym_o[2] !== 8'd6 || cnt_o[0] !== 8'd3) begin
         n_bad++;
         $display("FAIL hist_hold: got sv=%b sym3=%0d cnt1=%0d want 0/6/3",
                  bus.sort_valid, sym_o[2], cnt_o[0]);
      end
   endtask

   task automatic test_illegal();
      logic [7:0] q[$];
      logic [7:0] exp_sym[6];
      int   n;
      logic seen;
      q = '{8'd0, 8'd7, 8'd255, 8'd3};
      exp_sym = '{8'd3, 8'd1, 8'd2, 8'd4, 8'd5, 8'd6};
      send_frame(q);
      for (int i = 0; i < 6; i++) begin
         n_cmp++;
         if (cnt_o[i] !== ((i == 2) ? 8'd1 : 8'd0)) begin
            n_bad++;
            $display("FAIL illegal_cnt%0d: got %0d want %0d", i + 1, cnt_o[i], (i == 2) ? 1 : 0);
         end
      end
      wait_sort(n, seen);
      for (int i = 0; i < 6; i++) begin
         n_cmp++;
         if (sym_o[i] !== exp_sym[i]) begin
            n_bad++;
            $display("FAIL illegal_sym%0d: got %0d want %0d", i + 1, sym_o[i], exp_sym[i]);
         end
      end
   endtask

   task automatic test_wrap();
      logic [7:0] exp4;
      int   n;
      logic seen;
`ifdef CNT_SAT_EN
      exp4 = 8'd255;
`else
      exp4 = 8'd44;
`endif
      cyc(1'b0, 8'd0);
      for (int i = 0; i < 300; i++) cyc(1'b1, 8'd4);
      cyc(1'b0, 8'd0);
      n_cmp++;
      if (bus.CNT_valid !== 1'b1 || cnt_o[3] !== exp4 || cnt_o[0] !== 8'd0) begin
         n_bad++;
         $display("FAIL wrap_cnt4: got valid=%b cnt4=%0d cnt1=%0d want 1/%0d/0",
                  bus.CNT_valid, cnt_o[3], cnt_o[0], exp4);
      end
      wait_sort(n, seen);
      n_cmp++;
      if (n !== 6 || sym_o[0] !== 8'd4 || scnt_o[0] !== exp4) begin
         n_bad++;
         $display("FAIL wrap_sorted: got n=%0d sym1=%0d scnt1=%0d want 6/4/%0d",
                  n, sym_o[0], scnt_o[0], exp4);
      end
   endtask

   task automatic test_reset_abort();
      logic [7:0] q[$];
      logic       pulse;
      int   n;
      logic seen;
      q = '{8'd1, 8'd2, 8'd2};
      send_frame(q);
      repeat (2) cyc(1'b0, 8'd0);
      reset = 1'b0;
      #1;
      n_cmp++;
      if (cnt_o[1] !== 8'd0 || sym_o[0] !== 8'd1 || scnt_o[0] !== 8'd0 || bus.CNT_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL abort_reset_vals: got cnt2=%0d sym1=%0d scnt1=%0d cv=%b want 0/1/0/0",
                  cnt_o[1], sym_o[0], scnt_o[0], bus.CNT_valid);
      end
      pulse = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (bus.sort_valid || bus.CNT_valid) pulse = 1'b1;
      end
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 8'd0);
         if (bus.sort_valid || bus.CNT_valid) pulse = 1'b1;
      end
      n_cmp++;
      if (pulse !== 1'b0) begin
         n_bad++;
         $display("FAIL abort_no_pulse: got pulse=%b want 0", pulse);
      end
      q = '{8'd5, 8'd5};
      send_frame(q);
      n_cmp++;
      if (cnt_o[4] !== 8'd2 || cnt_o[0] !== 8'd0 || cnt_o[1] !== 8'd0) begin
         n_bad++;
         $display("FAIL abort_next_cnt: got cnt5=%0d cnt1=%0d cnt2=%0d want 2/0/0",
                  cnt_o[4], cnt_o[0], cnt_o[1]);
      end
      wait_sort(n, seen);
      n_cmp++;
      if (n !== 6 || sym_o[0] !== 8'd5 || scnt_o[0] !== 8'd2) begin
         n_bad++;
         $display("FAIL abort_next_sort: got n=%0d sym1=%0d scnt1=%0d want 6/5/2",
                  n, sym_o[0], scnt_o[0]);
      end
   endtask

   task automatic test_ignore_busy();
      logic [7:0] q[$];
      logic       sv6;
      logic       other;
      int   n;
      logic seen;
      q = '{8'd1, 8'd1, 8'd2};
      send_frame(q);
      sv6 = 1'b0;
      other = 1'b0;
      for (int j = 1; j <= 6; j++) begin
         cyc(1'b1, 8'd2);
         if (bus.CNT_valid) other = 1'b1;
         if (j < 6 && bus.sort_valid) other = 1'b1;
         if (j == 6) sv6 = bus.sort_valid;
      end
      n_cmp++;
      if (sv6 !== 1'b1 || other !== 1'b0) begin
         n_bad++;
         $display("FAIL busy_pulses: got sv6=%b stray=%b want 1/0", sv6, other);
      end
      n_cmp++;
      if (cnt_o[0] !== 8'd2 || cnt_o[1] !== 8'd1 || sym_o[0] !== 8'd1 || scnt_o[1] !== 8'd1) begin
         n_bad++;
         $display("FAIL busy_sort_counts: got cnt1=%0d cnt2=%0d sym1=%0d scnt2=%0d want 2/1/1/1",
                  cnt_o[0], cnt_o[1], sym_o[0], scnt_o[1]);
      end
      cyc(1'b1, 8'd2);
      n_cmp++;
      if (cnt_o[0] !== 8'd2 || cnt_o[1] !== 8'd1) begin
         n_bad++;
         $display("FAIL busy_done_drop: got cnt1=%0d cnt2=%0d want 2/1", cnt_o[0], cnt_o[1]);
      end
      cyc(1'b1, 8'd2);
      cyc(1'b0, 8'd0);
      n_cmp++;
      if (bus.CNT_valid !== 1'b1 || cnt_o[0] !== 8'd0 || cnt_o[1] !== 8'd1) begin
         n_bad++;
         $display("FAIL busy_new_frame: got cv=%b cnt1=%0d cnt2=%0d want 1/0/1",
                  bus.CNT_valid, cnt_o[0], cnt_o[1]);
      end
      wait_sort(n, seen);
      n_cmp++;
      if (n !== 6 || sym_o[0] !== 8'd2 || sym_o[1] !== 8'd1) begin
         n_bad++;
         $display("FAIL busy_new_sort: got n=%0d sym1=%0d sym2=%0d want 6/2/1", n, sym_o[0], sym_o[1]);
      end
   endtask

   task automatic test_single();
      logic [7:0] q[$];
      logic [7:0] exp_sym[6];
      int   n;
      logic seen;
      q = '{8'd6};
      exp_sym = '{8'd6, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
      send_frame(q);
      n_cmp++;
      if (bus.CNT_valid !== 1'b1 || cnt_o[5] !== 8'd1) begin
         n_bad++;
         $display("FAIL single_cnt: got cv=%b cnt6=%0d want 1/1", bus.CNT_valid, cnt_o[5]);
      end
      wait_sort(n, seen);
      n_cmp++;
      if (n !== 6) begin
         n_bad++;
         $display("FAIL single_latency: got %0d want 6", n);
      end
      for (int i = 0; i < 6; i++) begin
         n_cmp++;
         if (sym_o[i] !== exp_sym[i] || scnt_o[i] !== ((i == 0) ? 8'd1 : 8'd0)) begin
            n_bad++;
            $display("FAIL single_rank%0d: got sym=%0d scnt=%0d want %0d/%0d",
                     i + 1, sym_o[i], scnt_o[i], exp_sym[i], (i == 0) ? 1 : 0);
         end
      end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      test_reset();
      test_histogram();
      test_illegal();
      test_wrap();
      test_reset_abort();
      test_ignore_busy();
      test_single();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/symbol_hist_sort.md
SYMBOL_HIST_SORT -- requirements
Module: symbol_hist_sort

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-low reset (low = asserted).
REQ-003 SHALL have port gray_valid  input  1  qualifies gray_data on the current edge.
REQ-004 SHALL have port gray_data  input  8  symbol sample; legal symbols 1..6.
REQ-005 SHALL have ports CNT_valid  output  1  one-cycle pulse marking CNT1..CNT6 final for the frame.
REQ-006 SHALL have ports CNT1..CNT6  output  8 each  occurrence count of symbol 1..6.
REQ-007 SHALL have port sort_valid  output  1  one-cycle pulse marking the sorted outputs final.
REQ-008 SHALL have ports SYM1..SYM6  output  8 each  symbol IDs in descending count order, SYM1 = most frequent.
REQ-009 SHALL have ports SCNT1..SCNT6  output  8 each  count paired with SYM1..SYM6.

Function
REQ-010 SHALL implement FSM states IDLE, READ, SORT, DONE; all outputs registered.
REQ-011 IDLE: on an edge with gray_valid=1, SHALL clear all counts, count that sample, and go to READ.
REQ-012 READ: each edge with gray_valid=1 SHALL increment the counter matching gray_data.
REQ-013 gray_data of 0 or 7..255 SHALL be ignored: no counter changes, frame continues.
REQ-014 READ: the first edge sampling gray_valid=0 (edge k) SHALL go to SORT and drive CNT_valid=1 for exactly the cycle after edge k.
REQ-015 On entry to SORT, the working array SHALL load as (SYM,SCNT) = (1,CNT1)..(6,CNT6).
REQ-016 SORT SHALL perform odd-even transposition sort, one pass per edge at k+1..k+6: even pairs (1,2)(3,4)(5,6) on odd passes, odd pairs (2,3)(4,5) on even passes.
REQ-017 A pair SHALL swap only when the lower slot's count is strictly less than the upper slot's; ties therefore keep ascending symbol order.
REQ-018 Edge k+6 SHALL go to DONE; sort_valid SHALL be 1 for exactly the cycle after edge k+6; edge k+7 SHALL return to IDLE.
REQ-019 CNTn, SYMn and SCNTn SHALL hold their values from DONE until the next frame starts in IDLE.
REQ-020 gray_valid=1 during SORT or DONE SHALL be ignored; those samples are dropped.
REQ-021 CNT_valid and sort_valid SHALL never be high in the same cycle.
REQ-022 A frame of length 1 (single valid cycle) SHALL be processed normally.

Reset
REQ-023 While reset=0, the FSM SHALL be forced to IDLE regardless of clk.
REQ-024 Reset SHALL clear CNT1..CNT6, SCNT1..SCNT6, CNT_valid and sort_valid to 0.
REQ-025 Reset SHALL set SYMn to n (1..6).
REQ-026 Reset asserted mid-READ or mid-SORT SHALL abort the frame with no valid pulse; the next frame SHALL start clean.

Configuration
REQ-027 Macro CNT_SAT_EN, when defined, SHALL make each count saturate at 255.
REQ-028 Without CNT_SAT_EN, counts SHALL wrap modulo 256 (255+1 = 0).
REQ-029 Saturation/wrap SHALL apply equally to CNTn and the SCNTn values derived from them.

Verification
REQ-030 Stream 1,1,1,2,2,3,4,5,6,6 then gray_valid=0 -> CNT_valid pulse with CNT1..6 = 3,2,1,1,1,2.
REQ-031 Same stream, 6 cycles after CNT_valid -> sort_valid pulse; SYM = 1,2,6,3,4,5; SCNT = 3,2,2,1,1,1.
REQ-032 Stream 0,7,255,3 -> CNT3=1, all other counts 0; SYM = 3,1,2,4,5,6.
REQ-033 300 consecutive samples of 4 -> CNT4=255 with CNT_SAT_EN defined; CNT4=44 without it.
REQ-034 Reset pulled low at the 3rd SORT cycle -> no sort_valid, outputs at reset values; the following frame 5,5 -> SYM1=5, SCNT1=2.
REQ-035 gray_valid=1 with gray_data=2 held during SORT/DONE -> counts unchanged; the new frame begins only from IDLE.
